// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, angle landmarks and the 1/K shift-add recipe.
// Angles use the 16-bit binary-angle format where 0x8000 is pi.
package cordic_pkg;

    localparam logic [15:0] ANGLE_PI_2 = 16'd16384;
    localparam logic [15:0] ANGLE_PI   = 16'h8000;

    // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
    localparam int GAIN_TERMS = 5;
    localparam logic [GAIN_TERMS-1:0][3:0] GAIN_SHIFT = {4'd13, 4'd9, 4'd6, 4'd3, 4'd1};
    localparam logic [GAIN_TERMS-1:0]      GAIN_NEG   = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_RUN   = 2'd2
    } cordic_state_e;

    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 16'd8192;
            4'd1:    return 16'd4836;
            4'd2:    return 16'd2555;
            4'd3:    return 16'd1297;
            4'd4:    return 16'd651;
            4'd5:    return 16'd326;
            4'd6:    return 16'd163;
            4'd7:    return 16'd81;
            4'd8:    return 16'd41;
            4'd9:    return 16'd20;
            4'd10:   return 16'd10;
            4'd11:   return 16'd5;
            4'd12:   return 16'd3;
            4'd13:   return 16'd1;
            4'd14:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Combinational multiply by 1/K using the shared arithmetic-shift recipe.
// The caller registers the result.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int W = 18
) (
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] dout
);

    logic signed [W-1:0] acc;
    logic signed [W-1:0] term;

    // The coefficient is below 1, so no partial sum can outgrow W bits
    always_comb begin
        acc  = '0;
        term = '0;
        for (int i = 0; i < GAIN_TERMS; i++) begin
            term = din >>> GAIN_SHIFT[i];
            if (GAIN_NEG[i]) acc = acc - term;
            else             acc = acc + term;
        end
        dout = acc;
    end

endmodule

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: (mag, angle) -> (mag*cos, mag*sin).
// One micro-rotation per clock, start/done handshake, saturated outputs.
module cordic_rotate
    import cordic_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 16,
    parameter int COMP_GAIN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] mag_in,
    input  logic signed [WIDTH-1:0] angle_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic                    done,
    output logic                    busy
);

    localparam int XW = WIDTH + 2;
    localparam int IW = 5;

    // Rescale the 16-bit angle constants to the configured word width
    localparam int ATAN_LSH = (WIDTH >= 16) ? WIDTH - 16 : 0;
    localparam int ATAN_RSH = (WIDTH >= 16) ? 0 : 16 - WIDTH;
    localparam logic signed [WIDTH-1:0] HALF_PI     = WIDTH'((32'(ANGLE_PI_2) << ATAN_LSH) >> ATAN_RSH);
    localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;
    localparam logic        [WIDTH-1:0] PI_MSB      = WIDTH'((32'(ANGLE_PI) << ATAN_LSH) >> ATAN_RSH);
    localparam logic signed [XW-1:0]    SAT_MAX     = XW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [XW-1:0]    SAT_MIN     = ~SAT_MAX;

    function automatic logic [WIDTH-1:0] atan_w(input logic [3:0] i);
        return WIDTH'((32'(atan_lut(i)) << ATAN_LSH) >> ATAN_RSH);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        else                  return v[WIDTH-1:0];
    endfunction

    cordic_state_e           state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic [IW-1:0]           iter_q, iter_d;
    logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic                    done_q, done_d, busy_q, busy_d;

    logic signed [XW-1:0]    x_scaled;
    logic signed [XW-1:0]    x_sh, y_sh, mag_ext;
    logic [WIDTH-1:0]        at;

    cordic_gain_comp #(.W(XW)) u_gain (
        .din  (x_q),
        .dout (x_scaled)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mag_ext = {{2{mag_in[WIDTH-1]}}, mag_in};
        x_sh    = x_q >>> iter_q;
        y_sh    = y_q >>> iter_q;
        at      = atan_w(iter_q[3:0]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    iter_d = '0;
                    y_d    = '0;
                    // Fold the left half-plane into range by a 180 degree pre-rotation
                    if (angle_in > HALF_PI || angle_in < NEG_HALF_PI) begin
                        x_d = -mag_ext;
                        z_d = angle_in ^ PI_MSB;
                    end else begin
                        x_d = mag_ext;
                        z_d = angle_in;
                    end
                    state_d = (COMP_GAIN != 0) ? ST_SCALE : ST_RUN;
                end
            end
            ST_SCALE: begin
                x_d     = x_scaled;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (iter_q == IW'(STAGES)) begin
                    x_out_d = sat(x_q);
                    y_out_d = sat(y_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (!z_q[WIDTH-1]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - at;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + at;
                    end
                    iter_d = iter_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
